// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared constants and types for the HDMI period scheduler.
// Guard-band symbols, preamble control codes, period lengths, FSM states.
package hdmi_pkg;

    localparam int PRE_LEN = 8;
    localparam int GB_LEN  = 2;

    localparam logic [1:0] PRE_VID_CH1 = 2'b01;
    localparam logic [1:0] PRE_VID_CH2 = 2'b00;

    localparam logic [9:0] GB_VID_CH0 = 10'b1011001100;
    localparam logic [9:0] GB_VID_CH1 = 10'b0100110011;
    localparam logic [9:0] GB_VID_CH2 = 10'b1011001100;

    typedef enum logic [1:0] {
        ST_CTRL,
        ST_PRE,
        ST_GUARD,
        ST_VIDEO
    } state_t;

    // One raw timing sample as carried through the lookahead line.
    typedef struct packed {
        logic        de;
        logic        vsync;
        logic        hsync;
        logic [23:0] rgb;
    } tim_t;

endpackage

// File: rtl/hdmi_delay_line.sv
// hdmi_delay_line: fixed-depth shift register, cleared to 0 on reset.
// Ports: clk, resetn (async, active-low), din[WIDTH], dout[WIDTH] (DEPTH cycles later).
module hdmi_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/hdmi_period_sched.sv
// hdmi_period_sched: schedules control / preamble / guard / video periods for
// three TMDS encoders. In: clk, resetn, de_in, hsync_in, vsync_in, rgb_in[24].
// Out: enc_de, enc_ctrl[6], enc_din[24], guard_en, guard_sym[30], err_short.
module hdmi_period_sched
    import hdmi_pkg::*;
#(
    parameter bit HDMI_MODE = 1'b1,
    parameter int LAT       = 11,
    parameter int MIN_BLANK = 14,
    parameter int ENC_LAT   = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [23:0] rgb_in,
    output logic        enc_de,
    output logic [5:0]  enc_ctrl,
    output logic [23:0] enc_din,
    output logic        guard_en,
    output logic [29:0] guard_sym,
    output logic        err_short
);

    localparam int BW = $clog2(MIN_BLANK + 1);
    localparam logic [BW-1:0] BLANK_SAT = BW'(MIN_BLANK);

    tim_t tin;
    tim_t tap;

    state_t state;
    state_t state_n;
    logic [3:0] slot;
    logic [3:0] slot_n;
    logic [BW-1:0] blank_cnt;
    logic de_prev;

    logic rise;
    logic go_pre;
    logic fall_back;

    logic        de_n;
    logic [5:0]  ctrl_n;
    logic [23:0] din_n;
    logic        gen_n;
    logic [29:0] gsym_n;
    logic [30:0] guard_q;
    logic [30:0] guard_d;

    assign tin = '{de: de_in, vsync: vsync_in, hsync: hsync_in, rgb: rgb_in};

    // Lookahead: the output register adds the last cycle of LAT.
    hdmi_delay_line #(
        .WIDTH ($bits(tim_t)),
        .DEPTH (LAT - 1)
    ) u_look (
        .clk    (clk),
        .resetn (resetn),
        .din    (tin),
        .dout   (tap)
    );

    // The rise is seen 10 cycles before its pixel leaves, which is exactly
    // the room needed for preamble plus guard band.
    assign rise = de_in & ~de_prev;
    assign go_pre = rise & HDMI_MODE & (blank_cnt >= BLANK_SAT)
                  & (state == ST_CTRL) & ~tap.de;
    assign fall_back = rise & HDMI_MODE & ~go_pre;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_prev   <= 1'b0;
            blank_cnt <= '0;
            err_short <= 1'b0;
        end else begin
            de_prev <= de_in;
            if (de_in) begin
                blank_cnt <= '0;
            end else if (blank_cnt != BLANK_SAT) begin
                blank_cnt <= blank_cnt + BW'(1);
            end
            if (fall_back) err_short <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        slot_n  = slot;
        unique case (state)
            ST_CTRL: begin
                if (tap.de) begin
                    state_n = ST_VIDEO;
                end else if (go_pre) begin
                    state_n = ST_PRE;
                    slot_n  = '0;
                end
            end
            ST_PRE: begin
                if (slot == 4'(PRE_LEN - 1)) begin
                    state_n = ST_GUARD;
                    slot_n  = '0;
                end else begin
                    slot_n = slot + 4'd1;
                end
            end
            ST_GUARD: begin
                if (slot == 4'(GB_LEN - 1)) begin
                    state_n = tap.de ? ST_VIDEO : ST_CTRL;
                    slot_n  = '0;
                end else begin
                    slot_n = slot + 4'd1;
                end
            end
            ST_VIDEO: begin
                if (!tap.de) state_n = ST_CTRL;
            end
            default: begin
                state_n = ST_CTRL;
                slot_n  = '0;
            end
        endcase
    end

    // Output drive is decoded from the state being entered, so that the
    // registered outputs and the state register describe the same slot.
    always_comb begin
        de_n   = 1'b0;
        ctrl_n = '0;
        din_n  = '0;
        gen_n  = 1'b0;
        gsym_n = '0;
        unique case (state_n)
            ST_CTRL: begin
                ctrl_n = {4'b0000, tap.vsync, tap.hsync};
            end
            ST_PRE: begin
                ctrl_n = {PRE_VID_CH2, PRE_VID_CH1, tap.vsync, tap.hsync};
            end
            ST_GUARD: begin
                ctrl_n = {PRE_VID_CH2, PRE_VID_CH1, tap.vsync, tap.hsync};
                gen_n  = 1'b1;
                gsym_n = {GB_VID_CH2, GB_VID_CH1, GB_VID_CH0};
            end
            ST_VIDEO: begin
                de_n  = 1'b1;
                din_n = tap.rgb;
            end
            default: begin
                ctrl_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_CTRL;
            slot     <= '0;
            enc_de   <= 1'b0;
            enc_ctrl <= '0;
            enc_din  <= '0;
            guard_q  <= '0;
        end else begin
            state    <= state_n;
            slot     <= slot_n;
            enc_de   <= de_n;
            enc_ctrl <= ctrl_n;
            enc_din  <= din_n;
            guard_q  <= {gen_n, gsym_n};
        end
    end

    // guard_q is slot-aligned with enc_*; delay it to meet encoder dout.
    hdmi_delay_line #(
        .WIDTH (31),
        .DEPTH (ENC_LAT)
    ) u_galign (
        .clk    (clk),
        .resetn (resetn),
        .din    (guard_q),
        .dout   (guard_d)
    );

    assign guard_en  = guard_d[30];
    assign guard_sym = guard_d[29:0];

endmodule

// File: tb/tb_hdmi_period_sched.sv
// tb_hdmi_period_sched: directed checks of an HDMI-mode and a DVI-mode
// instance driven by identical timing stimulus.
module tb_hdmi_period_sched;

    localparam int N = 512;
    localparam logic [29:0] GB =
        {10'b1011001100, 10'b0100110011, 10'b1011001100};

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        de_in = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [23:0] rgb_in = '0;

    logic        h_de, d_de;
    logic [5:0]  h_ct, d_ct;
    logic [23:0] h_din, d_din;
    logic        h_ge, d_ge;
    logic [29:0] h_gs, d_gs;
    logic        h_err, d_err;

    always #5 clk = ~clk;

    hdmi_period_sched #(.HDMI_MODE(1'b1)) u_h (
        .clk(clk), .resetn(resetn), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .enc_de(h_de), .enc_ctrl(h_ct), .enc_din(h_din),
        .guard_en(h_ge), .guard_sym(h_gs), .err_short(h_err)
    );

    hdmi_period_sched #(.HDMI_MODE(1'b0)) u_d (
        .clk(clk), .resetn(resetn), .de_in(de_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .enc_de(d_de), .enc_ctrl(d_ct), .enc_din(d_din),
        .guard_en(d_ge), .guard_sym(d_gs), .err_short(d_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic        lde  [2][N];
    logic [5:0]  lct  [2][N];
    logic [23:0] ldin [2][N];
    logic        lge  [2][N];
    logic [29:0] lgs  [2][N];
    logic        lerr [2][N];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Input cycle cyc; after the edge the outputs are output cycle cyc+1.
    task automatic drive(input logic de, input logic [23:0] rgb);
        de_in    = de;
        rgb_in   = rgb;
        hsync_in = cyc[0];
        vsync_in = cyc[1];
        @(posedge clk);
        #1;
        if (cyc + 1 < N) begin
            lde[0][cyc+1]  = h_de;  lde[1][cyc+1]  = d_de;
            lct[0][cyc+1]  = h_ct;  lct[1][cyc+1]  = d_ct;
            ldin[0][cyc+1] = h_din; ldin[1][cyc+1] = d_din;
            lge[0][cyc+1]  = h_ge;  lge[1][cyc+1]  = d_ge;
            lgs[0][cyc+1]  = h_gs;  lgs[1][cyc+1]  = d_gs;
            lerr[0][cyc+1] = h_err; lerr[1][cyc+1] = d_err;
        end
        cyc++;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0);
    endtask

    task automatic active(input int n, input int base);
        for (int i = 0; i < n; i++) drive(1'b1, 24'(base + i));
    endtask

    // Line whose de_in rose at input cycle t, len pixels starting at base.
    task automatic chk_line(input int sel, input int t, input int len,
                            input int base, input bit pre, input int first);
        string nm;
        int x;
        nm = (sel == 0) ? "hdmi" : "dvi";
        for (int o = t + first; o <= t + 11 + len; o++) begin
            x = o - 11;
            if (o <= t + 10) begin
                chk($sformatf("%s ctl_hi o=%0d", nm, o - t),
                    32'(lct[sel][o][5:2]), pre ? 32'd1 : 32'd0);
                chk($sformatf("%s ctl_sync o=%0d", nm, o - t),
                    32'(lct[sel][o][1:0]), 32'(x[1:0]));
                chk($sformatf("%s de_lo o=%0d", nm, o - t),
                    32'(lde[sel][o]), 32'd0);
                chk($sformatf("%s din_lo o=%0d", nm, o - t),
                    32'(ldin[sel][o]), 32'd0);
                chk($sformatf("%s guard_en o=%0d", nm, o - t),
                    32'(lge[sel][o+3]), (pre && o >= t + 9) ? 32'd1 : 32'd0);
                if (pre && o >= t + 9)
                    chk($sformatf("%s guard_sym o=%0d", nm, o - t),
                        32'(lgs[sel][o+3]), 32'(GB));
            end else if (o <= t + 10 + len) begin
                chk($sformatf("%s vid_de o=%0d", nm, o - t),
                    32'(lde[sel][o]), 32'd1);
                chk($sformatf("%s vid_din o=%0d", nm, o - t),
                    32'(ldin[sel][o]), 32'(base + o - t - 11));
                chk($sformatf("%s vid_ctl o=%0d", nm, o - t),
                    32'(lct[sel][o]), 32'd0);
                chk($sformatf("%s vid_guard o=%0d", nm, o - t),
                    32'(lge[sel][o+3]), 32'd0);
            end else begin
                chk($sformatf("%s end_de o=%0d", nm, o - t),
                    32'(lde[sel][o]), 32'd0);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " h_de"}, 32'(h_de), 32'd0);
        chk({tag, " h_ctrl"}, 32'(h_ct), 32'd0);
        chk({tag, " h_din"}, 32'(h_din), 32'd0);
        chk({tag, " h_gen"}, 32'(h_ge), 32'd0);
        chk({tag, " h_gsym"}, 32'(h_gs), 32'd0);
        chk({tag, " h_err"}, 32'(h_err), 32'd0);
        chk({tag, " d_de"}, 32'(d_de), 32'd0);
        chk({tag, " d_ctrl"}, 32'(d_ct), 32'd0);
    endtask

    initial begin
        int t, t2, t3, t4, t5, x;

        // Reset state.
        drive(1'b0, 24'h0);
        chk_zero("reset");
        drive(1'b0, 24'h0);
        drive(1'b0, 24'h0);
        resetn = 1'b1;

        // Qualified line: 20 blank, 16 active, counts 1..16.
        blank(20);
        t = cyc;
        active(16, 1);
        blank(20);
        for (int o = t - 3; o <= t; o++) begin
            x = o - 11;
            chk($sformatf("ctrl_sync_blank o=%0d", o - t),
                32'(lct[0][o]), 32'(x[1:0]));
            chk($sformatf("dvi_sync_blank o=%0d", o - t),
                32'(lct[1][o]), 32'(x[1:0]));
        end
        chk_line(0, t, 16, 1, 1'b1, 1);
        chk_line(1, t, 16, 1, 1'b0, 1);
        chk("err_after_line1", 32'(h_err), 32'd0);

        // 4 active, 5 blank, 4 active: second rise lands in GUARD.
        t2 = cyc;
        active(4, 'h10);
        blank(5);
        active(4, 'h20);
        blank(20);
        chk_line(0, t2, 4, 'h10, 1'b1, 1);
        chk_line(0, t2 + 9, 4, 'h20, 1'b0, 6);
        chk_line(1, t2, 4, 'h10, 1'b0, 1);
        chk_line(1, t2 + 9, 4, 'h20, 1'b0, 6);
        chk("err_pre_rise2", 32'(lerr[0][t2+9]), 32'd0);
        chk("err_post_rise2", 32'(lerr[0][t2+10]), 32'd1);
        chk("dvi_err_454", 32'(d_err), 32'd0);

        // Reset, then only 12 blank cycles before the first line.
        resetn = 1'b0;
        #1;
        chk("err_cleared", 32'(h_err), 32'd0);
        drive(1'b0, 24'h0);
        resetn = 1'b1;
        blank(12);
        t3 = cyc;
        active(8, 'h40);
        blank(20);
        chk_line(0, t3, 8, 'h40, 1'b0, 1);
        chk_line(1, t3, 8, 'h40, 1'b0, 1);
        chk("err_short_at_rise", 32'(lerr[0][t3]), 32'd0);
        chk("err_short_set", 32'(lerr[0][t3+1]), 32'd1);
        chk("err_short_sticky", 32'(h_err), 32'd1);
        chk("dvi_err_short", 32'(d_err), 32'd0);

        // Qualified line aborted by reset in its first GUARD slot.
        t4 = cyc;
        active(9, 'h50);
        chk("in_guard", 32'(h_ct[5:2]), 32'd1);
        resetn = 1'b0;
        #1;
        chk_zero("mid_guard_reset");
        drive(1'b0, 24'h0);
        drive(1'b0, 24'h0);
        drive(1'b0, 24'h0);
        chk("guard_flushed", 32'(h_ge), 32'd0);
        resetn = 1'b1;

        // Exactly MIN_BLANK blank cycles qualifies.
        blank(14);
        t5 = cyc;
        active(3, 'h60);
        blank(20);
        chk_line(0, t5, 3, 'h60, 1'b1, 1);
        chk_line(1, t5, 3, 'h60, 1'b0, 1);
        chk("err_after_boundary", 32'(h_err), 32'd0);
        if (t4 < 0) chk("unused", 32'd0, 32'd1);

        for (int o = 1; o <= cyc && o < N; o++)
            chk($sformatf("dvi_guard_off c=%0d", o), 32'(lge[1][o]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
